memory_access: RTL and testbench
================================

// Module: memory_access
// PURPOSE
//   Pipeline stage directly downstream of decode/execute. Takes the ALU result and
//   store operand for one instruction and runs load/store transactions on a
//   req/ack data-memory bus. Handles byte/half/word sizing, sign/zero extension and
//   alignment checks, then presents one registered writeback record to the
//   register-file write stage. Stalls upstream via ready_o while a transaction is open.
// PARAMETERS
//   ADDR_W   32  byte-address width of alu_result_i / mem_addr_o
//   DATA_W   32  data width; fixed at 32, lane logic assumes 4 byte lanes
// PORTS
//   i_clk          in   1       clock, rising edge
//   i_rst          in   1       synchronous reset, active-high
//   i_en           in   1       stage enable; 0 = freeze all state and outputs
//   valid_i        in   1       instruction present on inputs this cycle
//   ready_o        out  1       stage can accept; high only in IDLE
//   rd_i           in   5       destination register
//   fun3_i         in   3       funct3 size/sign code
//   load_i         in   1       instruction is a load
//   store_i        in   1       instruction is a store
//   write_reg_i    in   1       instruction writes rd (from execute write_reg_file_wire)
//   alu_result_i   in   ADDR_W  effective address (mem ops) or result (others)
//   store_data_i   in   32      rs2 value for stores
//   mem_req_o      out  1       bus request, held until ack
//   mem_we_o       out  1       1 = write
//   mem_addr_o     out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
//   mem_wdata_o    out  32      store data, replicated across lanes
//   mem_wstrb_o    out  4       byte-lane strobes (0 for reads)
//   mem_rdata_i    in   32      read data, valid in the ack cycle
//   mem_ack_i      in   1       transaction complete
//   wb_valid_o     out  1       writeback record valid, one-cycle pulse
//   wb_we_o        out  1       write rd (0 for stores, errors, rd==0)
//   wb_rd_o        out  5       destination register
//   wb_data_o      out  32      writeback data
//   err_o          out  1       one-cycle pulse: misaligned / illegal fun3 / load&store
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0 except ready_o=1. Reset mid-WAIT drops mem_req_o
//     on the reset edge; the in-flight op is discarded, no wb_valid_o or err_o.
//   i_en=0: FSM, captured fields and all outputs hold (wb_valid_o/err_o included);
//     mem_ack_i is ignored and must be held by the bus.
//   FSM IDLE: on i_en & valid_i (accept edge T), capture inputs.
//     Non-memory (load_i=store_i=0): wb_valid_o=1 at T+1, wb_data_o=alu_result_i,
//       wb_we_o=write_reg_i & (rd_i!=0). Stay IDLE (back-to-back, 1/cycle).
//     Error: err_o=1 and wb_valid_o=1 with wb_we_o=0 at T+1; no bus access; stay IDLE.
//       Errors: load_i & store_i; fun3 illegal (load: 011,110,111; store: >010);
//       half with addr[0]=1; word with addr[1:0]!=0.
//     Legal mem op: go WAIT; mem_req_o/we/addr/wdata/wstrb driven from T+1.
//   FSM WAIT: ready_o=0; bus outputs stable. On the edge sampling mem_ack_i=1: go IDLE,
//     wb_valid_o=1 next cycle; minimum mem-op latency 2 cycles. mem_req_o low in IDLE.
//   Loads: lane = addr[1:0] (byte) or addr[1] (half); 000 LB / 001 LH sign-extend,
//     100 LBU / 101 LHU zero-extend, 010 LW whole word. wb_we_o=(rd!=0).
//   Stores: SB wstrb=0001<<addr[1:0], wdata={4{b}}; SH wstrb=0011<<{addr[1],1'b0},
//     wdata={2{h}}; SW wstrb=1111. wb_we_o=0, wb_data_o=0.
//   mem_ack_i while IDLE ignored. valid_i while ready_o=0 not accepted; upstream holds.
// TESTING
//   1 Assert i_rst 2 cycles mid-WAIT -> mem_req_o=0, wb_valid_o=0, ready_o=1 next cycle.
//   2 Non-mem rd=5 alu=0x1234 write_reg=1 -> T+1 wb_valid=1 rd=5 data=0x1234 we=1;
//     rd=0 same -> we=0.
//   3 LB addr 0x103, rdata 0x80FFFFFF, ack at T+1 -> mem_addr 0x100, wb_data 0xFFFFFF80;
//     LBU -> 0x00000080.
//   4 SH addr 0x102 data 0x1234ABCD, ack 3 cycles late -> wstrb 1100, wdata 0xABCDABCD,
//     ready_o low 4 cycles, wb_we=0.
//   5 LW addr 0x101 -> err_o pulse at T+1, mem_req_o never high; load&store both set -> err_o.
//   6 i_en=0 for 3 cycles during WAIT with ack held -> outputs frozen, completes after i_en=1.

Source files
------------

// File: rtl/memory_access.sv
// memory_access: load/store stage driving a req/ack data bus and producing one registered writeback record
module memory_access #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [4:0]        rd_i,
    input  logic [2:0]        fun3_i,
    input  logic              load_i,
    input  logic              store_i,
    input  logic              write_reg_i,
    input  logic [ADDR_W-1:0] alu_result_i,
    input  logic [DATA_W-1:0] store_data_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [3:0]        mem_wstrb_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              wb_valid_o,
    output logic              wb_we_o,
    output logic [4:0]        wb_rd_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic              err_o
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t state, state_nx;
    logic [4:0]        rd_q;
    logic [2:0]        fun3_q;
    logic              store_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] sdata_q;
    logic              accept, mem_op, bad, legal, done;
    logic [DATA_W-1:0] lane, load_data, wdata;
    logic [3:0]        strb;

    assign accept = i_en & valid_i & (state == S_IDLE);
    assign mem_op = load_i | store_i;
    assign bad    = (load_i & store_i)
                  | (load_i ? (fun3_i == 3'b011 || fun3_i[2:1] == 2'b11) : fun3_i > 3'b010)
                  | (fun3_i[1:0] == 2'b01 & alu_result_i[0])
                  | (fun3_i[1:0] == 2'b10 & |alu_result_i[1:0]);
    assign legal  = mem_op & ~bad;
    assign done   = i_en & (state == S_WAIT) & mem_ack_i;

    // Half-word lanes are always even, so a byte-granular shift serves both sizes.
    assign lane      = mem_rdata_i >> {addr_q[1:0], 3'b000};
    assign load_data = fun3_q[1:0] == 2'b00 ? {{24{~fun3_q[2] & lane[7]}}, lane[7:0]}
                     : fun3_q[1:0] == 2'b01 ? {{16{~fun3_q[2] & lane[15]}}, lane[15:0]}
                     : lane;
    assign strb      = fun3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0]
                     : fun3_q[1:0] == 2'b01 ? 4'b0011 << {addr_q[1], 1'b0}
                     : 4'b1111;
    assign wdata     = fun3_q[1:0] == 2'b00 ? {4{sdata_q[7:0]}}
                     : fun3_q[1:0] == 2'b01 ? {2{sdata_q[15:0]}}
                     : sdata_q;

    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= S_IDLE;
        else if (i_en)
            state <= state_nx;
    end

    always_comb begin
        state_nx = state == S_IDLE ? (accept & legal ? S_WAIT : S_IDLE)
                                   : (mem_ack_i ? S_IDLE : S_WAIT);
    end

    always_comb begin
        ready_o     = state == S_IDLE;
        mem_req_o   = state == S_WAIT;
        mem_we_o    = mem_req_o & store_q;
        mem_addr_o  = mem_req_o ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
        mem_wstrb_o = mem_we_o ? strb : 4'b0000;
        mem_wdata_o = mem_we_o ? wdata : '0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_q    <= '0;
            fun3_q  <= '0;
            store_q <= 1'b0;
            addr_q  <= '0;
            sdata_q <= '0;
        end else if (accept) begin
            rd_q    <= rd_i;
            fun3_q  <= fun3_i;
            store_q <= store_i;
            addr_q  <= alu_result_i;
            sdata_q <= store_data_i;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wb_valid_o <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_rd_o    <= '0;
            wb_data_o  <= '0;
            err_o      <= 1'b0;
        end else if (i_en) begin
            wb_valid_o <= done | (accept & ~legal);
            err_o      <= accept & mem_op & bad;
            if (done) begin
                wb_rd_o   <= rd_q;
                wb_we_o   <= ~store_q & |rd_q;
                wb_data_o <= store_q ? '0 : load_data;
            end else if (accept & ~legal) begin
                wb_rd_o   <= rd_i;
                wb_we_o   <= ~mem_op & write_reg_i & |rd_i;
                wb_data_o <= mem_op ? '0 : DATA_W'(alu_result_i);
            end
        end
    end
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: vector table plus corner sequences, writeback checked through a scoreboard queue
module tb_memory_access;
    logic        i_clk = 1'b0, i_rst = 1'b1, i_en = 1'b1, valid_i = 1'b0;
    logic        ready_o, load_i = 1'b0, store_i = 1'b0, write_reg_i = 1'b0;
    logic [4:0]  rd_i = '0;
    logic [2:0]  fun3_i = '0;
    logic [31:0] alu_result_i = '0, store_data_i = '0, mem_rdata_i = '0;
    logic        mem_ack_i = 1'b0, mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o, wb_data_o;
    logic [3:0]  mem_wstrb_o;
    logic        wb_valid_o, wb_we_o, err_o;
    logic [4:0]  wb_rd_o;

    memory_access dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .valid_i(valid_i), .ready_o(ready_o),
        .rd_i(rd_i), .fun3_i(fun3_i), .load_i(load_i), .store_i(store_i),
        .write_reg_i(write_reg_i), .alu_result_i(alu_result_i), .store_data_i(store_data_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o), .mem_rdata_i(mem_rdata_i),
        .mem_ack_i(mem_ack_i), .wb_valid_o(wb_valid_o), .wb_we_o(wb_we_o),
        .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .err_o(err_o)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [4:0]  rd;
        logic [2:0]  fun3;
        logic        ld, st, wr;
        logic [31:0] alu, sdata, rdata;
        int          dly;
        logic        err, we;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
        logic        err;
    } wb_t;

    wb_t  sbq[$];
    wb_t  exp_wb;
    int   n_cmp = 0, n_bad = 0;
    logic en_q = 1'b0, rst_q = 1'b1;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(logic [4:0] rd, logic [2:0] fun3, logic ld, logic st, logic wr,
                                logic [31:0] alu, logic [31:0] sdata, logic [31:0] rdata, int dly,
                                logic err, logic we, logic [31:0] data, logic [3:0] strb,
                                logic [31:0] wdata);
        vec_t v;
        v.rd = rd; v.fun3 = fun3; v.ld = ld; v.st = st; v.wr = wr;
        v.alu = alu; v.sdata = sdata; v.rdata = rdata; v.dly = dly;
        v.err = err; v.we = we; v.data = data; v.strb = strb; v.wdata = wdata;
        return v;
    endfunction

    always @(posedge i_clk) begin
        en_q  <= i_en;
        rst_q <= i_rst;
    end

    // A writeback is new only if the edge that produced it was enabled.
    always @(negedge i_clk) begin
        if (!rst_q && en_q && wb_valid_o) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL wb_unexpected: got rd=%0d data=%0h want none", wb_rd_o, wb_data_o);
            end else begin
                exp_wb = sbq.pop_front();
                check("wb_rd_we_err", {wb_rd_o, wb_we_o, err_o}, {exp_wb.rd, exp_wb.we, exp_wb.err});
                if (!exp_wb.err)
                    check("wb_data", wb_data_o, exp_wb.data);
            end
        end
    end

    task automatic drive(logic [4:0] rd, logic [2:0] fun3, logic ld, logic st, logic wr,
                         logic [31:0] alu, logic [31:0] sdata);
        valid_i = 1'b1; rd_i = rd; fun3_i = fun3; load_i = ld; store_i = st;
        write_reg_i = wr; alu_result_i = alu; store_data_i = sdata;
    endtask

    task automatic apply(vec_t v);
        int   lowcnt;
        logic legal;
        legal = (v.ld | v.st) & ~v.err;
        for (int i = 0; i < 20 && !ready_o; i++) @(negedge i_clk);
        if (!ready_o) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: got 0 want 1");
        end
        drive(v.rd, v.fun3, v.ld, v.st, v.wr, v.alu, v.sdata);
        sbq.push_back('{v.rd, v.we, v.data, v.err});
        @(negedge i_clk);
        valid_i = 1'b0;
        if (legal) begin
            check("bus", {mem_req_o, mem_we_o, mem_addr_o, mem_wstrb_o},
                  {1'b1, v.st, v.alu & ~32'h3, v.strb});
            if (v.st) check("wdata", mem_wdata_o, v.wdata);
            lowcnt = 0;
            for (int i = 0; i < v.dly; i++) begin
                lowcnt += int'(!ready_o);
                @(negedge i_clk);
            end
            lowcnt += int'(!ready_o);
            if (v.dly > 0)
                check("bus_hold", {mem_req_o, mem_addr_o, mem_wstrb_o},
                      {1'b1, v.alu & ~32'h3, v.strb});
            mem_ack_i = 1'b1;
            mem_rdata_i = v.rdata;
            @(negedge i_clk);
            mem_ack_i = 1'b0;
            mem_rdata_i = '0;
            check("ready_low_cycles", lowcnt, v.dly + 1);
            check("idle_after_ack", {ready_o, mem_req_o}, 2'b10);
        end else begin
            check("no_bus", {ready_o, mem_req_o}, 2'b10);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[18];
        vecs[0]  = mk(5,  3'b000, 0, 0, 1, 32'h1234,     0, 0,            0, 0, 1, 32'h1234,     4'b0000, 0);
        vecs[1]  = mk(0,  3'b000, 0, 0, 1, 32'h1234,     0, 0,            0, 0, 0, 32'h1234,     4'b0000, 0);
        vecs[2]  = mk(7,  3'b000, 1, 0, 1, 32'h103,      0, 32'h80FFFFFF, 0, 0, 1, 32'hFFFFFF80, 4'b0000, 0);
        vecs[3]  = mk(7,  3'b100, 1, 0, 1, 32'h103,      0, 32'h80FFFFFF, 0, 0, 1, 32'h00000080, 4'b0000, 0);
        vecs[4]  = mk(8,  3'b001, 1, 0, 1, 32'h102,      0, 32'h80011234, 1, 0, 1, 32'hFFFF8001, 4'b0000, 0);
        vecs[5]  = mk(9,  3'b101, 1, 0, 1, 32'h100,      0, 32'h8001F234, 0, 0, 1, 32'h0000F234, 4'b0000, 0);
        vecs[6]  = mk(10, 3'b010, 1, 0, 1, 32'h104,      0, 32'hDEADBEEF, 2, 0, 1, 32'hDEADBEEF, 4'b0000, 0);
        vecs[7]  = mk(11, 3'b001, 0, 1, 0, 32'h102, 32'h1234ABCD, 0,      3, 0, 0, 0,            4'b1100, 32'hABCDABCD);
        vecs[8]  = mk(12, 3'b000, 0, 1, 0, 32'h101, 32'h000000A5, 0,      0, 0, 0, 0,            4'b0010, 32'hA5A5A5A5);
        vecs[9]  = mk(13, 3'b010, 0, 1, 0, 32'h108, 32'hCAFEF00D, 0,      1, 0, 0, 0,            4'b1111, 32'hCAFEF00D);
        vecs[10] = mk(3,  3'b010, 1, 0, 1, 32'h101,      0, 0,            0, 1, 0, 0,            4'b0000, 0);
        vecs[11] = mk(4,  3'b010, 1, 1, 1, 32'h100,      0, 0,            0, 1, 0, 0,            4'b0000, 0);
        vecs[12] = mk(6,  3'b001, 1, 0, 1, 32'h101,      0, 0,            0, 1, 0, 0,            4'b0000, 0);
        vecs[13] = mk(6,  3'b011, 1, 0, 1, 32'h100,      0, 0,            0, 1, 0, 0,            4'b0000, 0);
        vecs[14] = mk(6,  3'b011, 0, 1, 0, 32'h100,      0, 0,            0, 1, 0, 0,            4'b0000, 0);
        vecs[15] = mk(31, 3'b000, 0, 0, 0, 32'hFFFF0000, 0, 0,            0, 0, 0, 32'hFFFF0000, 4'b0000, 0);
        vecs[16] = mk(1,  3'b000, 1, 0, 1, 32'h100,      0, 32'h0000007F, 0, 0, 1, 32'h0000007F, 4'b0000, 0);
        vecs[17] = mk(0,  3'b010, 1, 0, 1, 32'h200,      0, 32'h00000055, 1, 0, 0, 32'h00000055, 4'b0000, 0);

        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        check("reset_state",
              {ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wstrb_o, wb_valid_o, wb_we_o, wb_rd_o, err_o},
              {1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 5'h0, 1'b0});
        check("reset_data", {mem_wdata_o, wb_data_o}, 64'h0);

        foreach (vecs[i]) apply(vecs[i]);

        // back-to-back non-memory ops, one per cycle
        for (int i = 0; i < 3; i++) begin
            drive(5'(20 + i), 3'b000, 0, 0, 1, 32'hA0 + i, 0);
            sbq.push_back('{5'(20 + i), 1'b1, 32'hA0 + i, 1'b0});
            @(negedge i_clk);
            check("b2b_ready", ready_o, 1'b1);
        end
        valid_i = 1'b0;
        @(negedge i_clk);

        // ack while idle must not start or complete anything
        mem_ack_i = 1'b1;
        mem_rdata_i = 32'hFFFFFFFF;
        repeat (2) @(negedge i_clk);
        check("idle_ack_ignored", {ready_o, mem_req_o, wb_valid_o}, 3'b100);
        mem_ack_i = 1'b0;
        mem_rdata_i = '0;

        // reset in the middle of a transaction discards it
        drive(9, 3'b010, 1, 0, 1, 32'h40, 0);
        @(negedge i_clk);
        valid_i = 1'b0;
        check("pre_reset_req", mem_req_o, 1'b1);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("reset_mid_wait", {mem_req_o, wb_valid_o, ready_o, err_o}, 4'b0010);
        @(negedge i_clk);
        i_rst = 1'b0;
        check("reset_mid_wait2", {mem_req_o, wb_valid_o, ready_o, err_o}, 4'b0010);
        repeat (2) @(negedge i_clk);

        // enable low while waiting with ack already presented
        drive(14, 3'b010, 1, 0, 1, 32'h10, 0);
        sbq.push_back('{5'd14, 1'b1, 32'h11223344, 1'b0});
        @(negedge i_clk);
        valid_i = 1'b0;
        check("freeze_req", mem_req_o, 1'b1);
        mem_ack_i = 1'b1;
        mem_rdata_i = 32'h11223344;
        i_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            check("frozen_wait", {mem_req_o, ready_o, wb_valid_o, mem_addr_o}, {3'b100, 32'h10});
        end
        i_en = 1'b1;
        @(negedge i_clk);
        mem_ack_i = 1'b0;
        mem_rdata_i = '0;
        check("unfrozen_idle", {ready_o, mem_req_o, wb_valid_o}, 3'b101);

        // enable low holds a writeback pulse
        drive(17, 3'b000, 0, 0, 1, 32'h77, 0);
        sbq.push_back('{5'd17, 1'b1, 32'h77, 1'b0});
        @(negedge i_clk);
        valid_i = 1'b0;
        i_en = 1'b0;
        @(negedge i_clk);
        check("wb_hold", {wb_valid_o, wb_data_o}, {1'b1, 32'h77});
        @(negedge i_clk);
        i_en = 1'b1;
        @(negedge i_clk);
        check("wb_released", wb_valid_o, 1'b0);

        repeat (3) @(negedge i_clk);
        check("scoreboard_drain", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
